// File: rtl/grid_claim_arbiter.sv
// rtl/grid_claim_arbiter.sv - round-robin atomic test-and-set arbiter for the placement grid RAM
//
// Purpose:
//   Shares one placement grid RAM between N_REQ walkers. Each claim reads the
//   target cell and writes the walker's node id only if the cell holds EMPTY.
//   One claim is in flight at a time; walkers are served round-robin.
//
// Optional feature macro: GRID_CLAIM_STATS_EN
//   Defined   : claims_ok / claims_rej count accepted / rejected claims (wrap at 2^32).
//   Undefined : claims_ok / claims_rej are tied to 0.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req[N_REQ]              per-walker claim request (level, held until done)
//   req_x, req_y            signed target row / column per walker, slice i = [i*DATA_W +: DATA_W]
//   req_node                node id to store per walker
//   done[N_REQ]             one-cycle completion pulse to the served walker
//   ok                      claim result while a done bit is high (1 = cell won)
//   busy                    high while a claim is in progress
//   mem_re, mem_we          grid RAM read / write strobes (single cycle)
//   mem_addr, mem_din       grid RAM address / write data
//   mem_dout                grid RAM read data, valid two edges after mem_re rises
//   claims_ok, claims_rej   statistics counters

module grid_claim_arbiter #(
   parameter int N_REQ     = 4,
   parameter int GRID_SIDE = 11,
   parameter int DATA_W    = 32,
   parameter int EMPTY     = -1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_x,
   input  logic [N_REQ*DATA_W-1:0]   req_y,
   input  logic [N_REQ*DATA_W-1:0]   req_node,
   output logic [N_REQ-1:0]          done,
   output logic                      ok,
   output logic                      busy,
   output logic                      mem_re,
   output logic                      mem_we,
   output logic [DATA_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_din,
   input  logic [DATA_W-1:0]         mem_dout,
   output logic [31:0]               claims_ok,
   output logic [31:0]               claims_rej
);

   localparam int                 IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [DATA_W-1:0]  EMPTY_W = DATA_W'(EMPTY);
   localparam logic signed [31:0] SIDE_S  = 32'(GRID_SIDE);

   typedef enum logic [2:0] {IDLE, CHECK, WAIT, CAP, WR, RESP} state_t;

   state_t                    state;
   logic [IDX_W-1:0]          rr_ptr;
   logic [IDX_W-1:0]          idx;
   logic [N_REQ-1:0]          mask;
   logic signed [DATA_W-1:0]  cur_x;
   logic signed [DATA_W-1:0]  cur_y;
   logic [DATA_W-1:0]         cur_node;

   logic [N_REQ-1:0]          eligible;
   logic                      pick_found;
   logic [IDX_W-1:0]          pick_idx;
   logic [IDX_W-1:0]          next_ptr;
   logic signed [31:0]        x32;
   logic signed [31:0]        y32;
   logic signed [31:0]        addr32;
   logic                      out_of_bounds;

   // Round-robin pick: first eligible walker at or above rr_ptr, wrapping.
   // mask keeps the walker just served out of the very next IDLE cycle, while
   // its req may still be high for one cycle after done.
   always_comb begin
      eligible   = req & ~mask;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!pick_found && eligible[(int'(rr_ptr) + k) % N_REQ]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         end
      end
      next_ptr = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
   end

   // Address arithmetic is done in signed 32 bits, then truncated to DATA_W.
   always_comb begin
      x32           = 32'(cur_x);
      y32           = 32'(cur_y);
      addr32        = x32 * SIDE_S + y32;
      out_of_bounds = (x32 < 0) || (x32 >= SIDE_S) || (y32 < 0) || (y32 >= SIDE_S);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         idx      <= '0;
         mask     <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         cur_node <= '0;
         done     <= '0;
         ok       <= 1'b0;
         busy     <= 1'b0;
         mem_re   <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         done   <= '0;
         ok     <= 1'b0;
         mem_re <= 1'b0;
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               mask <= '0;
               if (pick_found) begin
                  idx      <= pick_idx;
                  cur_x    <= req_x[int'(pick_idx)*DATA_W +: DATA_W];
                  cur_y    <= req_y[int'(pick_idx)*DATA_W +: DATA_W];
                  cur_node <= req_node[int'(pick_idx)*DATA_W +: DATA_W];
                  rr_ptr   <= next_ptr;
                  busy     <= 1'b1;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (out_of_bounds) begin
                  done[idx] <= 1'b1;
                  ok        <= 1'b0;
                  state     <= RESP;
               end else begin
                  mem_re   <= 1'b1;
                  mem_addr <= DATA_W'(addr32);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               state <= CAP;
            end
            CAP: begin
               if (mem_dout == EMPTY_W) begin
                  mem_we  <= 1'b1;
                  mem_din <= cur_node;
                  state   <= WR;
               end else begin
                  done[idx] <= 1'b1;
                  ok        <= 1'b0;
                  state     <= RESP;
               end
            end
            WR: begin
               // The write issued in CAP lands on this edge; report the win.
               done[idx] <= 1'b1;
               ok        <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               mask  <= N_REQ'(1) << idx;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef GRID_CLAIM_STATS_EN
   // ok is high exactly during the RESP cycle of a won claim.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         claims_ok  <= '0;
         claims_rej <= '0;
      end else if (state == RESP) begin
         if (ok) claims_ok  <= claims_ok + 32'd1;
         else    claims_rej <= claims_rej + 32'd1;
      end
   end
`else
   assign claims_ok  = '0;
   assign claims_rej = '0;
`endif

endmodule

// File: tb/tb_grid_claim_arbiter.sv
// tb/tb_grid_claim_arbiter.sv - self-checking bench for grid_claim_arbiter
module tb_grid_claim_arbiter;

   logic          clk = 1'b0;
   logic          reset;
   logic [3:0]    req;
   logic [127:0]  req_x, req_y, req_node;
   logic [3:0]    done;
   logic          ok, busy, mem_re, mem_we;
   logic [31:0]   mem_addr, mem_din, mem_dout;
   logic [31:0]   claims_ok, claims_rej;

`ifdef GRID_CLAIM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   grid_claim_arbiter dut (
      .clk(clk), .reset(reset), .req(req),
      .req_x(req_x), .req_y(req_y), .req_node(req_node),
      .done(done), .ok(ok), .busy(busy),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .claims_ok(claims_ok), .claims_rej(claims_rej)
   );

   always #5 clk = ~clk;

   // Grid RAM model: registered read, so data sampled on the second edge after mem_re rises.
   logic [31:0] grid [0:127] = '{default: 32'hFFFF_FFFF};
   always @(posedge clk) begin
      if (mem_re) mem_dout <= grid[mem_addr[6:0]];
      if (mem_we) grid[mem_addr[6:0]] <= mem_din;
   end

   int re_cnt = 0, we_cnt = 0, cyc = 0;
   int last_we_addr = 0, last_we_din = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_re) re_cnt++;
      if (mem_we) begin
         we_cnt++;
         last_we_addr = int'(mem_addr);
         last_we_din  = int'(mem_din);
      end
   end

   int total = 0, bad = 0;
   int exp_ok_cnt = 0, exp_rej_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_ops(input int w, input int x, input int y, input int node);
      req_x[w*32 +: 32]    = x;
      req_y[w*32 +: 32]    = y;
      req_node[w*32 +: 32] = node;
   endtask

   typedef struct {
      int w; int x; int y; int node;
      int exp_ok; int exp_lat; int exp_re; int exp_we; int exp_addr;
   } vec_t;
   vec_t vecs[9];

   int srv_idx[4], srv_cyc[4], srv_ok[4];

   task automatic serve_loop(input int n);
      int served = 0;
      int guard  = 0;
      while (served < n && guard < 100) begin
         @(posedge clk); #1; guard++;
         for (int k = 0; k < 4; k++) begin
            if (done[k] && served < 4) begin
               srv_idx[served] = k;
               srv_cyc[served] = cyc;
               srv_ok[served]  = int'(ok);
               served++;
               req[k] = 1'b0;
            end
         end
      end
      check("serve_count", served, n);
   endtask

   initial begin
      reset = 1'b1; req = '0; req_x = '0; req_y = '0; req_node = '0;
      vecs[0] = '{0,  3,  4,   7, 1, 4, 1, 1,  37};
      vecs[1] = '{1,  3,  4,   9, 0, 3, 1, 0,  37};
      vecs[2] = '{2, 11,  0,  11, 0, 1, 0, 0,   0};
      vecs[3] = '{2, -1,  5,  12, 0, 1, 0, 0,   0};
      vecs[4] = '{3,  0,  0, 100, 1, 4, 1, 1,   0};
      vecs[5] = '{1, 10, 10,  55, 1, 4, 1, 1, 120};
      vecs[6] = '{0,  0, 11,  13, 0, 1, 0, 0,   0};
      vecs[7] = '{2, 10, -1,  14, 0, 1, 0, 0,   0};
      vecs[8] = '{3,  0,  0,   5, 0, 3, 1, 0,   0};

      @(negedge clk); @(negedge clk);
      check("rst_done",   int'(done), 0);
      check("rst_ok",     int'(ok), 0);
      check("rst_busy",   int'(busy), 0);
      check("rst_re",     int'(mem_re), 0);
      check("rst_we",     int'(mem_we), 0);
      check("rst_addr",   int'(mem_addr), 0);
      check("rst_din",    int'(mem_din), 0);
      check("rst_cnt_ok", int'(claims_ok), 0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven single claims.
      for (int v = 0; v < 9; v++) begin
         int re0, we0, lat;
         bit got;
         logic [3:0] dv;
         logic okv;
         got = 0; lat = 0; dv = '0; okv = 1'b0;
         re0 = re_cnt; we0 = we_cnt;
         set_ops(vecs[v].w, vecs[v].x, vecs[v].y, vecs[v].node);
         req[vecs[v].w] = 1'b1;
         @(posedge clk);
         while (!got && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (done != 0) begin got = 1; dv = done; okv = ok; end
         end
         check($sformatf("v%0d_done", v), int'(dv), 1 << vecs[v].w);
         check($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
         check($sformatf("v%0d_ok", v), int'(okv), vecs[v].exp_ok);
         @(negedge clk); req[vecs[v].w] = 1'b0;
         @(negedge clk); @(negedge clk);
         check($sformatf("v%0d_re", v), re_cnt - re0, vecs[v].exp_re);
         check($sformatf("v%0d_we", v), we_cnt - we0, vecs[v].exp_we);
         if (vecs[v].exp_we != 0) begin
            check($sformatf("v%0d_waddr", v), last_we_addr, vecs[v].exp_addr);
            check($sformatf("v%0d_wdin", v), last_we_din, vecs[v].node);
            check($sformatf("v%0d_cell", v), int'(grid[vecs[v].exp_addr]), vecs[v].node);
         end
         if (vecs[v].exp_ok != 0) exp_ok_cnt++; else exp_rej_cnt++;
      end
      check("cell37_kept", int'(grid[37]), 7);
      check("tbl_claims_ok",  int'(claims_ok),  STATS ? exp_ok_cnt  : 0);
      check("tbl_claims_rej", int'(claims_rej), STATS ? exp_rej_cnt : 0);

      // All four requesting from reset: order 0,1,2,3, done pulses 6 cycles apart.
      reset = 1'b1;
      set_ops(0, 1, 1, 200); set_ops(1, 1, 2, 201);
      set_ops(2, 2, 1, 202); set_ops(3, 2, 2, 203);
      req = 4'hF;
      @(negedge clk); reset = 1'b0;
      exp_ok_cnt = 0; exp_rej_cnt = 0;
      serve_loop(4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("all_order%0d", k), srv_idx[k], k);
         check($sformatf("all_ok%0d", k), srv_ok[k], 1);
         if (k > 0) check($sformatf("all_gap%0d", k), srv_cyc[k] - srv_cyc[k-1], 6);
      end
      exp_ok_cnt += 4;
      check("cell12", int'(grid[12]), 200);
      check("cell13", int'(grid[13]), 201);
      check("cell23", int'(grid[23]), 202);
      check("cell24", int'(grid[24]), 203);
      @(negedge clk); @(negedge clk);

      // Walkers 0 and 3 race for (5,5); rr_ptr has wrapped to 0 so walker 0 wins.
      set_ops(0, 5, 5, 300); set_ops(3, 5, 5, 333);
      req = 4'b1001;
      serve_loop(2);
      check("pair_first", srv_idx[0], 0);
      check("pair_first_ok", srv_ok[0], 1);
      check("pair_second", srv_idx[1], 3);
      check("pair_second_ok", srv_ok[1], 0);
      check("cell60", int'(grid[60]), 300);
      exp_ok_cnt += 1; exp_rej_cnt += 1;
      @(negedge clk); @(negedge clk);
      check("seq_claims_ok",  int'(claims_ok),  STATS ? exp_ok_cnt  : 0);
      check("seq_claims_rej", int'(claims_rej), STATS ? exp_rej_cnt : 0);

      // Reset during CAP of a claim to free cell (7,7) = 84.
      begin
         int we0;
         we0 = we_cnt;
         set_ops(2, 7, 7, 400);
         req[2] = 1'b1;
         @(posedge clk); @(posedge clk); @(posedge clk); #1;
         check("rc_busy_before", int'(busy), 1);
         reset = 1'b1;
         #1;
         check("rc_busy_async", int'(busy), 0);
         check("rc_we_async", int'(mem_we), 0);
         check("rc_done_async", int'(done), 0);
         @(negedge clk); req[2] = 1'b0;
         @(negedge clk); reset = 1'b0;
         repeat (4) @(negedge clk);
         check("rc_we_cnt", we_cnt - we0, 0);
         check("rc_cell84", int'(grid[84]), -1);
         check("rc_done", int'(done), 0);
         check("rc_claims_ok", int'(claims_ok), 0);
         check("rc_claims_rej", int'(claims_rej), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
